exu_csr_req: RTL and testbench

Initiator side of the execute-stage CSR access interface. Accepts one decoded CSR instruction (CSRRW/CSRRS/CSRRC and immediate forms) from the ALU dispatch path and sequences the read and write accesses to the CSR register file. Computes the new CSR value and returns the old value for register writeback through a valid/ready handshake. Occupies the slot between ALU dispatch and the CSR file / longpipe writeback arbiter.

---
 rtl/exu_csr_req_pkg.sv | 16 +
 rtl/exu_csr_req_alu.sv | 18 +
 rtl/exu_csr_req.sv | 146 ++++++++++++++
 tb/tb_exu_csr_req.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/exu_csr_req_pkg.sv
// exu_csr_req_pkg: shared data width, CSR op encodings and request FSM state encodings
package exu_csr_req_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {
    CSR_OP_RSV = 2'b00,
    CSR_OP_RW  = 2'b01,
    CSR_OP_RS  = 2'b10,
    CSR_OP_RC  = 2'b11
  } csr_op_e;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_WBCK  = 2'b11
  } csr_req_st_e;
endpackage

// File: rtl/exu_csr_req_alu.sv
// exu_csr_req_alu: combinational next-CSR-value computation
//   i_op   : CSR op (RW / RS / RC; reserved 00 behaves as RS)
//   i_rdat : current CSR value (0 when the read was skipped)
//   i_src  : rs1 value or zero-extended zimm
//   o_wdat : value to write back to the CSR
module exu_csr_req_alu
  import exu_csr_req_pkg::*;
(
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rdat,
  input  logic [XLEN-1:0] i_src,
  output logic [XLEN-1:0] o_wdat
);
  always_comb begin
    o_wdat = (i_op == CSR_OP_RW) ? i_src :
             (i_op == CSR_OP_RC) ? (i_rdat & ~i_src) : (i_rdat | i_src);
  end
endmodule

// File: rtl/exu_csr_req.sv
// exu_csr_req: execute-stage CSR access initiator (read / write sequencing + writeback handshake)
//   clk, rst_n        : clock, synchronous active-low reset
//   i_valid/i_ready   : decoded CSR instruction handshake (op, imm_sel, rs1, rd, csr index)
//   csr_*             : CSR file access strobes, index, write data; read_csr_dat / csr_access_ilgl back
//   o_wbck_*          : old-value writeback handshake with rd index, write enable and error flag
// Optional feature macro E203_CSR_REQ_FAST_EN merges READ and WRITE into a single ACCESS cycle.
module exu_csr_req
  import exu_csr_req_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic [1:0]      i_op,
  input  logic            i_imm_sel,
  input  logic [4:0]      i_rs1_idx,
  input  logic [XLEN-1:0] i_rs1_dat,
  input  logic [4:0]      i_rd_idx,
  input  logic [11:0]     i_csr_idx,
  output logic            csr_ena,
  output logic            csr_rd_en,
  output logic            csr_wr_en,
  output logic [11:0]     csr_idx,
  output logic [XLEN-1:0] wbck_csr_dat,
  input  logic [XLEN-1:0] read_csr_dat,
  input  logic            csr_access_ilgl,
  output logic            o_wbck_valid,
  input  logic            o_wbck_ready,
  output logic [XLEN-1:0] o_wbck_dat,
  output logic [4:0]      o_wbck_rdidx,
  output logic            o_wbck_rdwen,
  output logic            o_wbck_err
);
  csr_req_st_e     r_st;
  logic [1:0]      r_op;
  logic [XLEN-1:0] r_src, r_rdat, r_wdat;
  logic [4:0]      r_rd;
  logic [11:0]     r_csr_idx;
  logic            r_need_wr, r_csr_ena, r_csr_rd_en, r_csr_wr_en, r_valid, r_err, r_rdwen;
  logic [XLEN-1:0] w_src_in, w_alu, w_alu_rdat, w_alu_src;
  logic [1:0]      w_alu_op;
  logic            w_idle, w_need_rd, w_need_wr, w_go_wr;
  // One ALU serves both the write-only path (at accept, old value 0) and the read-then-write path.
  always_comb begin
    w_idle     = r_st == ST_IDLE;
    w_src_in   = i_imm_sel ? {{(XLEN-5){1'b0}}, i_rs1_idx} : i_rs1_dat;
    w_need_rd  = ~((i_op == CSR_OP_RW) & (i_rd_idx == 5'd0));
    w_need_wr  = (i_op == CSR_OP_RW) | (i_rs1_idx != 5'd0);
    w_alu_op   = w_idle ? i_op : r_op;
    w_alu_rdat = w_idle ? '0 : read_csr_dat;
    w_alu_src  = w_idle ? w_src_in : r_src;
`ifdef E203_CSR_REQ_FAST_EN
    w_go_wr    = 1'b0;
`else
    w_go_wr    = r_need_wr & ~csr_access_ilgl;
`endif
  end
  exu_csr_req_alu u_alu (
    .i_op   (w_alu_op),
    .i_rdat (w_alu_rdat),
    .i_src  (w_alu_src),
    .o_wdat (w_alu)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st        <= ST_IDLE;
      r_op        <= '0;
      r_src       <= '0;
      r_rdat      <= '0;
      r_wdat      <= '0;
      r_rd        <= '0;
      r_csr_idx   <= '0;
      r_need_wr   <= 1'b0;
      r_csr_ena   <= 1'b0;
      r_csr_rd_en <= 1'b0;
      r_csr_wr_en <= 1'b0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_rdwen     <= 1'b0;
    end else begin
      unique case (r_st)
        ST_IDLE: if (i_valid) begin
          r_op        <= i_op;
          r_src       <= w_src_in;
          r_rd        <= i_rd_idx;
          r_csr_idx   <= i_csr_idx;
          r_need_wr   <= w_need_wr;
          r_rdat      <= '0;
          r_wdat      <= w_alu;
          r_err       <= 1'b0;
          r_csr_ena   <= 1'b1;
          r_csr_rd_en <= w_need_rd;
`ifdef E203_CSR_REQ_FAST_EN
          r_csr_wr_en <= w_need_wr;
`else
          r_csr_wr_en <= ~w_need_rd;
`endif
          r_st        <= w_need_rd ? ST_READ : ST_WRITE;
        end
        // In the fast build this is the merged ACCESS cycle; w_go_wr is then always 0.
        ST_READ: begin
          r_rdat      <= read_csr_dat;
          r_wdat      <= w_alu;
          r_csr_ena   <= w_go_wr;
          r_csr_rd_en <= 1'b0;
          r_csr_wr_en <= w_go_wr;
          r_valid     <= ~w_go_wr;
          r_err       <= csr_access_ilgl;
          r_rdwen     <= ~w_go_wr & (r_rd != 5'd0) & ~csr_access_ilgl;
          r_st        <= w_go_wr ? ST_WRITE : ST_WBCK;
        end
        ST_WRITE: begin
          r_csr_ena   <= 1'b0;
          r_csr_wr_en <= 1'b0;
          r_valid     <= 1'b1;
          r_err       <= csr_access_ilgl;
          r_rdwen     <= (r_rd != 5'd0) & ~csr_access_ilgl;
          r_st        <= ST_WBCK;
        end
        default: if (o_wbck_ready) begin
          r_valid <= 1'b0;
          r_err   <= 1'b0;
          r_rdwen <= 1'b0;
          r_st    <= ST_IDLE;
        end
      endcase
    end
  end
  assign i_ready      = w_idle & rst_n;
  assign csr_ena      = r_csr_ena;
  assign csr_rd_en    = r_csr_rd_en;
  assign csr_idx      = r_csr_idx;
`ifdef E203_CSR_REQ_FAST_EN
  // Merged access: write data follows the live read data, and an illegal access never writes.
  assign csr_wr_en    = r_csr_wr_en & ~(r_csr_rd_en & csr_access_ilgl);
  assign wbck_csr_dat = (r_csr_rd_en & r_csr_wr_en) ? w_alu : r_wdat;
`else
  assign csr_wr_en    = r_csr_wr_en;
  assign wbck_csr_dat = r_wdat;
`endif
  assign o_wbck_valid = r_valid;
  assign o_wbck_dat   = r_err ? '0 : r_rdat;
  assign o_wbck_rdidx = r_rd;
  assign o_wbck_rdwen = r_rdwen;
  assign o_wbck_err   = r_err;
endmodule

// File: tb/tb_exu_csr_req.sv
// tb_exu_csr_req: self-checking bench for exu_csr_req against a transaction-level reference model
module tb_exu_csr_req;
  logic        clk, rst_n, i_valid, i_ready, i_imm_sel;
  logic [1:0]  i_op;
  logic [4:0]  i_rs1_idx, i_rd_idx, o_wbck_rdidx;
  logic [31:0] i_rs1_dat, wbck_csr_dat, read_csr_dat, o_wbck_dat;
  logic [11:0] i_csr_idx, csr_idx;
  logic        csr_ena, csr_rd_en, csr_wr_en, csr_access_ilgl;
  logic        o_wbck_valid, o_wbck_ready, o_wbck_rdwen, o_wbck_err;
  logic        t_ilgl_rd, t_ilgl_wr;
  int          errors = 0;
  int          checks = 0;

  exu_csr_req dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready), .i_op(i_op),
    .i_imm_sel(i_imm_sel), .i_rs1_idx(i_rs1_idx), .i_rs1_dat(i_rs1_dat), .i_rd_idx(i_rd_idx),
    .i_csr_idx(i_csr_idx), .csr_ena(csr_ena), .csr_rd_en(csr_rd_en), .csr_wr_en(csr_wr_en),
    .csr_idx(csr_idx), .wbck_csr_dat(wbck_csr_dat), .read_csr_dat(read_csr_dat),
    .csr_access_ilgl(csr_access_ilgl), .o_wbck_valid(o_wbck_valid), .o_wbck_ready(o_wbck_ready),
    .o_wbck_dat(o_wbck_dat), .o_wbck_rdidx(o_wbck_rdidx), .o_wbck_rdwen(o_wbck_rdwen),
    .o_wbck_err(o_wbck_err)
  );

  // Responder: flags the read phase or the write phase as illegal as the transaction requests.
  assign csr_access_ilgl = csr_ena & (csr_rd_en ? t_ilgl_rd : t_ilgl_wr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic do_txn(input string name, input logic [1:0] op, input logic imm,
                        input logic [4:0] rs1i, input logic [31:0] rs1d, input logic [4:0] rd,
                        input logic [11:0] csr, input logic [31:0] rdv, input logic ilr,
                        input logic ilw, input int stall);
    logic [31:0] src, old, e_wdat, e_dat, wdat;
    logic        need_rd, need_wr, e_err, e_rdwen;
    int          e_rd, e_wr, e_v, rd_c, wr_c, v_c, n_wr;
    src     = imm ? {27'b0, rs1i} : rs1d;
    need_rd = !(op == 2'b01 && rd == 5'd0);
    need_wr = (op == 2'b01) || (rs1i != 5'd0);
    if (need_rd) begin
      e_rd = 1;
      if (ilr) begin e_err = 1'b1; e_wr = -1; e_v = 2; end
      else if (need_wr) begin e_err = ilw; e_wr = 2; e_v = 3; end
      else begin e_err = 1'b0; e_wr = -1; e_v = 2; end
    end else begin
      e_rd = -1; e_wr = 1; e_v = 2; e_err = ilw;
    end
    old     = need_rd ? rdv : 32'h0;
    e_wdat  = (op == 2'b01) ? src : (op == 2'b11) ? (old & ~src) : (old | src);
    e_dat   = e_err ? 32'h0 : old;
    e_rdwen = (rd != 5'd0) && !e_err;
    @(negedge clk);
    checks++;
    if (i_ready !== 1'b1) begin errors++; $display("FAIL %s i_ready_idle: got %b want 1", name, i_ready); end
    i_valid = 1'b1; i_op = op; i_imm_sel = imm; i_rs1_idx = rs1i; i_rs1_dat = rs1d;
    i_rd_idx = rd; i_csr_idx = csr; read_csr_dat = rdv; t_ilgl_rd = ilr; t_ilgl_wr = ilw;
    o_wbck_ready = 1'b0;
    @(posedge clk);
    #1;
    i_valid = 1'b0; i_op = 2'($urandom); i_imm_sel = 1'($urandom); i_rs1_idx = 5'($urandom);
    i_rs1_dat = $urandom; i_rd_idx = 5'($urandom); i_csr_idx = 12'($urandom);
    rd_c = -1; wr_c = -1; v_c = -1; n_wr = 0; wdat = 32'h0;
    for (int c = 1; c <= 8 && v_c < 0; c++) begin
      @(negedge clk);
      if (csr_ena && csr_rd_en) begin
        rd_c = c;
        checks++;
        if (csr_idx !== csr) begin errors++; $display("FAIL %s csr_idx: got %h want %h", name, csr_idx, csr); end
      end
      if (csr_ena && csr_wr_en) begin wr_c = c; n_wr++; wdat = wbck_csr_dat; end
      if (o_wbck_valid === 1'b1) v_c = c;
    end
    checks++;
    if (v_c != e_v) begin errors++; $display("FAIL %s valid_cycle: got %0d want %0d", name, v_c, e_v); end
    checks++;
    if (rd_c != e_rd) begin errors++; $display("FAIL %s read_cycle: got %0d want %0d", name, rd_c, e_rd); end
    checks++;
    if (wr_c != e_wr || n_wr != (e_wr > 0 ? 1 : 0)) begin
      errors++; $display("FAIL %s write_cycle: got %0d (count %0d) want %0d", name, wr_c, n_wr, e_wr);
    end
    if (e_wr > 0) begin
      checks++;
      if (wdat !== e_wdat) begin errors++; $display("FAIL %s write_data: got %h want %h", name, wdat, e_wdat); end
    end
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) @(negedge clk);
      checks++;
      if ({o_wbck_valid, o_wbck_dat, o_wbck_rdidx, o_wbck_rdwen, o_wbck_err, i_ready} !==
          {1'b1, e_dat, rd, e_rdwen, e_err, 1'b0}) begin
        errors++;
        $display("FAIL %s wbck[%0d]: got v=%b dat=%h rd=%0d wen=%b err=%b rdy=%b want v=1 dat=%h rd=%0d wen=%b err=%b rdy=0",
                 name, s, o_wbck_valid, o_wbck_dat, o_wbck_rdidx, o_wbck_rdwen, o_wbck_err, i_ready,
                 e_dat, rd, e_rdwen, e_err);
      end
    end
    o_wbck_ready = 1'b1;
    @(posedge clk);
    #1;
    o_wbck_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (o_wbck_valid !== 1'b0 || i_ready !== 1'b1) begin
      errors++; $display("FAIL %s post_handshake: got v=%b rdy=%b want v=0 rdy=1", name, o_wbck_valid, i_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({i_ready, csr_ena, csr_rd_en, csr_wr_en, o_wbck_valid, o_wbck_err, o_wbck_rdwen} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy=%b ena=%b rd=%b wr=%b v=%b err=%b wen=%b want all 0",
               i_ready, csr_ena, csr_rd_en, csr_wr_en, o_wbck_valid, o_wbck_err, o_wbck_rdwen);
    end
    checks++;
    if ({o_wbck_dat, o_wbck_rdidx, csr_idx, wbck_csr_dat} !== 81'b0) begin
      errors++;
      $display("FAIL reset_data: got dat=%h rd=%0d idx=%h wdat=%h want all 0",
               o_wbck_dat, o_wbck_rdidx, csr_idx, wbck_csr_dat);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (i_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", i_ready); end
  endtask

  task automatic test_directed();
    do_txn("csrrw_x5",      2'b01, 1'b0, 5'd6, 32'h1234_5678, 5'd5, 12'h300, 32'h0000_0088, 1'b0, 1'b0, 0);
    do_txn("csrrs_x2",      2'b10, 1'b0, 5'd2, 32'h0000_0008, 5'd9, 12'h304, 32'h0000_0080, 1'b0, 1'b0, 1);
    do_txn("csrrci_zero",   2'b11, 1'b1, 5'd0, 32'hffff_ffff, 5'd3, 12'h341, 32'hdead_beef, 1'b0, 1'b0, 0);
    do_txn("csrrw_rd0",     2'b01, 1'b0, 5'd4, 32'hcafe_f00d, 5'd0, 12'h305, 32'h5555_5555, 1'b0, 1'b0, 0);
    do_txn("csrrs_ilgl_rd", 2'b10, 1'b0, 5'd7, 32'h0000_00ff, 5'd8, 12'hfff, 32'h1111_2222, 1'b1, 1'b0, 0);
    do_txn("csrrc_ilgl_wr", 2'b11, 1'b0, 5'd1, 32'h0000_000f, 5'd2, 12'h7c0, 32'h0000_00ff, 1'b0, 1'b1, 0);
    do_txn("csrrsi_op00",   2'b00, 1'b1, 5'd19, 32'h0,        5'd31, 12'h300, 32'h0000_0100, 1'b0, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      do_txn("random", 2'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom,
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), 12'($urandom), $urandom,
             $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3));
    end
  endtask

  task automatic test_backpressure_reset();
    @(negedge clk);
    i_valid = 1'b1; i_op = 2'b10; i_imm_sel = 1'b0; i_rs1_idx = 5'd3; i_rs1_dat = 32'h5;
    i_rd_idx = 5'd7; i_csr_idx = 12'h305; read_csr_dat = 32'h11; t_ilgl_rd = 1'b0; t_ilgl_wr = 1'b0;
    o_wbck_ready = 1'b0;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    for (int c = 0; c < 8 && o_wbck_valid !== 1'b1; c++) @(negedge clk);
    checks++;
    if (o_wbck_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout: got %b want 1", o_wbck_valid); end
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      checks++;
      if ({o_wbck_valid, o_wbck_dat, o_wbck_rdidx, o_wbck_rdwen, o_wbck_err, i_ready} !==
          {1'b1, 32'h11, 5'd7, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_stall[%0d]: got v=%b dat=%h rd=%0d wen=%b err=%b rdy=%b want v=1 dat=11 rd=7 wen=1 err=0 rdy=0",
                 s, o_wbck_valid, o_wbck_dat, o_wbck_rdidx, o_wbck_rdwen, o_wbck_err, i_ready);
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_wbck_valid, i_ready, csr_ena} !== 3'b0) begin
      errors++; $display("FAIL bp_reset: got v=%b rdy=%b ena=%b want 0 0 0", o_wbck_valid, i_ready, csr_ena);
    end
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      checks++;
      if ({o_wbck_valid, csr_ena, i_ready} !== 3'b001) begin
        errors++; $display("FAIL bp_after_reset[%0d]: got v=%b ena=%b rdy=%b want 0 0 1", s, o_wbck_valid, csr_ena, i_ready);
      end
    end
    i_valid = 1'b1; i_op = 2'b01; i_rs1_idx = 5'd9; i_rd_idx = 5'd1; i_csr_idx = 12'h340;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({csr_ena, csr_rd_en, csr_wr_en} !== 3'b110) begin
      errors++; $display("FAIL mid_read_state: got ena=%b rd=%b wr=%b want 1 1 0", csr_ena, csr_rd_en, csr_wr_en);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      checks++;
      if ({csr_ena, o_wbck_valid} !== 2'b00) begin
        errors++; $display("FAIL mid_read_reset[%0d]: got ena=%b v=%b want 0 0", s, csr_ena, o_wbck_valid);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_op = 2'b0; i_imm_sel = 1'b0; i_rs1_idx = 5'd0; i_rs1_dat = 32'h0;
    i_rd_idx = 5'd0; i_csr_idx = 12'h0; read_csr_dat = 32'h0; o_wbck_ready = 1'b0;
    t_ilgl_rd = 1'b0; t_ilgl_wr = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure_reset();
    test_directed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
